// File: rtl/viking_vram_responder_pkg.sv
// Shared types and timebase constants for the Viking video memory path.
package viking_pkg;

    localparam int ADDR_W      = 23;
    localparam int BLOCK_WORDS = 4;

    localparam logic [5:0] SAMPLE    = 6'h11;
    localparam logic [5:0] DEADLINE  = 6'h1E;
    localparam logic [3:0] CLK8_LOAD = 4'hD;

    typedef enum logic [1:0] {
        IDLE,
        DEMAND,
        PREFETCH,
        DRAIN
    } state_t;

    // Address of the following 4-word block; wraps modulo 2^23.
    function automatic logic [ADDR_W-1:0] next_block(input logic [ADDR_W-1:0] addr);
        return addr + ADDR_W'(BLOCK_WORDS);
    endfunction

endpackage

// File: rtl/viking_vram_responder_if.sv
// Fetcher read port plus SDRAM request/acknowledge port of the video responder.
interface viking_vram_if;
    import viking_pkg::*;

    logic [ADDR_W-1:0] vaddr;
    logic              vread;
    logic [63:0]       vdata;
    logic              ram_req;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_ack;
    logic [63:0]       ram_data;

    modport master (
        output vaddr, vread, ram_ack, ram_data,
        input  vdata, ram_req, ram_addr
    );

    modport slave (
        input  vaddr, vread, ram_ack, ram_data,
        output vdata, ram_req, ram_addr
    );

endinterface

// File: rtl/viking_vram_responder_phase_gen.sv
// Bus-cycle phase generator: t realigns to each clk_8_en rising edge, phase = {bus_cycle, t} registered.
module viking_phase_gen
    import viking_pkg::*;
(
    input  logic       pclk,
    input  logic       reset,
    input  logic       clk_8_en,
    input  logic [1:0] bus_cycle,
    output logic [5:0] phase
);

    logic       clk8_d_reg;
    logic [3:0] t_reg;
    logic [5:0] phase_reg;

    always_ff @(posedge pclk) begin
        if (reset) begin
            clk8_d_reg <= 1'b0;
            t_reg      <= 4'd0;
            phase_reg  <= 6'd0;
        end else begin
            clk8_d_reg <= clk_8_en;
            t_reg      <= (clk_8_en && !clk8_d_reg) ? CLK8_LOAD : t_reg + 4'd1;
            phase_reg  <= {bus_cycle, t_reg};
        end
    end

    assign phase = phase_reg;

endmodule

// File: rtl/viking_vram_responder.sv
// Video read responder: serves the fetcher at a fixed latch point, hides SDRAM latency with a one-block prefetch.
module viking_vram_responder
    import viking_pkg::*;
(
    input  logic         pclk,
    input  logic         reset,
    input  logic         clk_8_en,
    input  logic [1:0]   bus_cycle,
    viking_vram_if.slave vram,
    output logic         late,
    output logic [15:0]  miss_cnt
);

    logic [5:0] phase;

    viking_phase_gen u_phase_gen (
        .pclk      (pclk),
        .reset     (reset),
        .clk_8_en  (clk_8_en),
        .bus_cycle (bus_cycle),
        .phase     (phase)
    );

    state_t            state_reg, state_next;
    logic              pf_valid_reg, pf_valid_next;
    logic [ADDR_W-1:0] pf_addr_reg, pf_addr_next;
    logic [63:0]       pf_data_reg, pf_data_next;
    logic [ADDR_W-1:0] req_addr_reg, req_addr_next;
    logic [63:0]       vdata_reg, vdata_next;
    logic              waiting_reg, waiting_next;
    logic              late_reg, late_next;
    logic [15:0]       miss_cnt_reg, miss_cnt_next;
    logic              ram_req_reg, ram_req_next;
    logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;

    logic ack;
    logic inflight;
    logic hit;

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_reg    <= IDLE;
            pf_valid_reg <= 1'b0;
            pf_addr_reg  <= '0;
            pf_data_reg  <= '0;
            req_addr_reg <= '0;
            vdata_reg    <= '0;
            waiting_reg  <= 1'b0;
            late_reg     <= 1'b0;
            miss_cnt_reg <= '0;
            ram_req_reg  <= 1'b0;
            ram_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pf_valid_reg <= pf_valid_next;
            pf_addr_reg  <= pf_addr_next;
            pf_data_reg  <= pf_data_next;
            req_addr_reg <= req_addr_next;
            vdata_reg    <= vdata_next;
            waiting_reg  <= waiting_next;
            late_reg     <= late_next;
            miss_cnt_reg <= miss_cnt_next;
            ram_req_reg  <= ram_req_next;
            ram_addr_reg <= ram_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pf_valid_next = pf_valid_reg;
        pf_addr_next  = pf_addr_reg;
        pf_data_next  = pf_data_reg;
        req_addr_next = req_addr_reg;
        vdata_next    = vdata_reg;
        waiting_next  = waiting_reg;
        late_next     = late_reg;
        miss_cnt_next = miss_cnt_reg;
        ram_addr_next = ram_addr_reg;

        // An acknowledge is handled before the sample so a same-cycle sample sees its effect.
        ack = vram.ram_ack && ram_req_reg;
        if (ack) begin
            unique case (state_reg)
                DEMAND: begin
                    vdata_next    = vram.ram_data;
                    pf_addr_next  = next_block(req_addr_reg);
                    pf_valid_next = 1'b0;
                    waiting_next  = 1'b0;
                    state_next    = PREFETCH;
                end
                PREFETCH: begin
                    pf_data_next  = vram.ram_data;
                    pf_valid_next = 1'b1;
                    state_next    = IDLE;
                end
                DRAIN:   state_next = DEMAND;
                default: ;
            endcase
        end

        inflight = ram_req_reg && !ack;
        hit      = pf_valid_next && (pf_addr_next == vram.vaddr);

        if (phase == DEADLINE && waiting_reg) begin
            late_next = 1'b1;
        end

        if (phase == SAMPLE && vram.vread) begin
            req_addr_next = vram.vaddr;
            if (hit) begin
                vdata_next    = pf_data_next;
                pf_addr_next  = next_block(vram.vaddr);
                pf_valid_next = 1'b0;
                waiting_next  = 1'b0;
                state_next    = PREFETCH;
            end else begin
                // A stale buffer entry must not satisfy a later read while a demand is open.
                pf_valid_next = 1'b0;
                waiting_next  = 1'b1;
                if (miss_cnt_reg != 16'hFFFF) begin
                    miss_cnt_next = miss_cnt_reg + 16'd1;
                end
                if (!inflight) begin
                    state_next = DEMAND;
                end else if (state_reg != DRAIN && ram_addr_reg == vram.vaddr) begin
                    state_next = DEMAND;
                end else begin
                    state_next = DRAIN;
                end
            end
        end

        // Address follows the state that owns the bus; DRAIN keeps the outstanding one.
        ram_req_next = (state_next != IDLE);
        unique case (state_next)
            DEMAND:   ram_addr_next = req_addr_next;
            PREFETCH: ram_addr_next = pf_addr_next;
            default:  ram_addr_next = ram_addr_reg;
        endcase
        ram_addr_next[1:0] = 2'b00;
    end

    assign vram.vdata    = vdata_reg;
    assign vram.ram_req  = ram_req_reg;
    assign vram.ram_addr = ram_addr_reg;
    assign late          = late_reg;
    assign miss_cnt      = miss_cnt_reg;

endmodule

// File: tb/tb_viking_vram_responder.sv
// Randomised bench for viking_vram_responder with a block-level read/prefetch reference model.
module tb_viking_vram_responder;

    localparam logic [22:0] AMASK = 23'h7FFFFF;

    logic        pclk = 1'b0;
    logic        reset;
    logic        clk_8_en;
    logic [1:0]  bus_cycle;
    logic        late;
    logic [15:0] miss_cnt;

    viking_vram_if vram();

    viking_vram_responder dut (
        .pclk      (pclk),
        .reset     (reset),
        .clk_8_en  (clk_8_en),
        .bus_cycle (bus_cycle),
        .vram      (vram),
        .late      (late),
        .miss_cnt  (miss_cnt)
    );

    always #4 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    int c      = 0;
    int ph     = 0;

    // backend model
    logic        bk_en;
    logic        bk_busy;
    logic [22:0] bk_addr;
    int          bk_cnt;

    // reference model
    logic        pf_done;
    logic [22:0] pf_expect;
    logic        dem_pending;
    logic [22:0] dem_addr;
    int          dem_tgt;
    int          pf_dly;
    logic [63:0] exp_v;
    logic [63:0] old_v;
    logic        late_exp;
    int          miss_exp;
    logic        noise;

    function automatic logic [63:0] mem_word(input logic [22:0] a);
        return {~a, 9'h0A5, a, 9'h13C};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s phase=%h got=%h exp=%h", tag, ph[5:0], got, exp);
        end
    endtask

    // One pclk interval: advance the fetcher timebase so the DUT phase equals c%64, then serve the backend.
    task automatic tick();
        @(posedge pclk);
        #1;
        c++;
        ph        = c % 64;
        clk_8_en  = (c % 16 == 11);
        bus_cycle = 2'(((c + 1) % 64) / 16);
        vram.ram_ack  = 1'b0;
        vram.ram_data = {$urandom, $urandom};
        if (bk_en) begin
            if (bk_busy) begin
                check("ram_hold", 64'({vram.ram_req, vram.ram_addr}), 64'({1'b1, bk_addr}));
                if (bk_cnt <= 0) begin
                    vram.ram_ack  = 1'b1;
                    vram.ram_data = mem_word(bk_addr);
                    bk_busy = 1'b0;
                    if (bk_addr == pf_expect) pf_done = 1'b1;
                end else begin
                    bk_cnt--;
                end
            end else if (vram.ram_req) begin
                bk_busy = 1'b1;
                bk_addr = vram.ram_addr;
                check("ram_align", 64'(vram.ram_addr[1:0]), 64'd0);
                if (dem_pending) begin
                    check("dem_addr", 64'(vram.ram_addr), 64'(dem_addr));
                    bk_cnt = dem_tgt - ph - 1;
                    dem_pending = 1'b0;
                end else begin
                    check("pf_addr", 64'(vram.ram_addr), 64'(pf_expect));
                    bk_cnt = pf_dly;
                end
            end
        end
    endtask

    // One 64-interval memory cycle; a read is presented through bus cycle 1.
    task automatic run_cycle(input logic rd, input logic [22:0] addr, input int tgt, input int pdly);
        logic hit;
        hit    = 1'b0;
        pf_dly = pdly;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (ph >= 'h10 && ph <= 'h1F) begin
                vram.vread = rd;
                vram.vaddr = addr;
            end else if (noise) begin
                vram.vread = 1'($urandom);
                vram.vaddr = 23'($urandom);
            end else begin
                vram.vread = 1'b0;
            end
            if (rd) begin
                if (ph == 'h11) begin
                    check("vdata_pre", vram.vdata, exp_v);
                    hit = pf_done && (addr == pf_expect);
                    if (!hit) begin
                        dem_pending = 1'b1;
                        dem_addr    = addr;
                        dem_tgt     = tgt;
                        if (miss_exp < 65535) miss_exp++;
                        if (tgt >= 'h1E) late_exp = 1'b1;
                    end
                    pf_expect = (addr + 23'd4) & AMASK;
                    pf_done   = 1'b0;
                    old_v     = exp_v;
                    exp_v     = mem_word(addr);
                    $display("read addr=%h hit=%0d ack_phase=%h", addr, hit, tgt[5:0]);
                end
                if (hit && ph == 'h12) check("hit_data", vram.vdata, exp_v);
                if (!hit && ph > 'h11 && ph == tgt) check("miss_hold", vram.vdata, old_v);
                if (!hit && ph > 'h12 && ph == tgt + 1) check("miss_data", vram.vdata, exp_v);
                if (ph == 'h1E) check("deadline_vdata", vram.vdata, (hit || tgt <= 'h1D) ? exp_v : old_v);
            end
            if (ph == 'h3F) begin
                check("late", 64'(late), 64'(late_exp));
                check("miss_cnt", 64'(miss_cnt), 64'(miss_exp));
                check("vdata_end", vram.vdata, exp_v);
            end
        end
    endtask

    initial begin
        logic [22:0] raddr;
        reset = 1'b1;
        clk_8_en = 1'b0;
        bus_cycle = 2'd0;
        vram.vread = 1'b0;
        vram.vaddr = '0;
        vram.ram_ack = 1'b0;
        vram.ram_data = '0;
        bk_en = 1'b0;
        bk_busy = 1'b0;
        bk_addr = '0;
        bk_cnt = 0;
        pf_done = 1'b0;
        pf_expect = '0;
        dem_pending = 1'b0;
        dem_addr = '0;
        dem_tgt = 0;
        pf_dly = 0;
        exp_v = '0;
        old_v = '0;
        late_exp = 1'b0;
        miss_exp = 0;
        noise = 1'b0;

        repeat (5) tick();
        check("rst_vdata", vram.vdata, 64'd0);
        check("rst_ram_req", 64'(vram.ram_req), 64'd0);
        check("rst_ram_addr", 64'(vram.ram_addr), 64'd0);
        check("rst_late", 64'(late), 64'd0);
        check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
        reset = 1'b0;
        bk_en = 1'b1;
        while (ph != 63) tick();

        // directed scenarios
        run_cycle(1'b1, 23'h600000, 'h18, 2);
        run_cycle(1'b1, 23'h600004, 'h18, 1);
        run_cycle(1'b1, 23'h600008, 'h18, 1);
        run_cycle(1'b1, 23'h123450, 'h1F, 2);
        run_cycle(1'b0, 23'h000000, 'h18, 2);
        run_cycle(1'b1, 23'h123454, 'h18, 2);
        run_cycle(1'b1, 23'h600000, 'h14, 62);
        run_cycle(1'b1, 23'h740000, 'h1A, 2);
        run_cycle(1'b1, 23'h7FFFFC, 'h16, 2);
        run_cycle(1'b1, 23'h000000, 'h18, 2);

        // random sequential runs, jumps, idle cycles and stray vread noise
        noise = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int          r;
            logic [22:0] a;
            r = $urandom_range(0, 3);
            a = (r < 2) ? pf_expect : (23'($urandom) & 23'h7FFFFC);
            run_cycle(r != 3, a, $urandom_range('h14, 'h26), $urandom_range(0, 8));
        end
        noise = 1'b0;
        vram.vread = 1'b0;

        // reset while a demand is outstanding, then a stray acknowledge
        bk_en = 1'b0;
        raddr = (pf_expect + 23'h000100) & AMASK;
        do tick(); while (ph != 'h10);
        vram.vread = 1'b1;
        vram.vaddr = raddr;
        repeat (4) tick();
        vram.vread = 1'b0;
        check("req_before_reset", 64'({vram.ram_req, vram.ram_addr}), 64'({1'b1, raddr}));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vram.ram_ack = 1'b1;
        check("mid_rst_vdata", vram.vdata, 64'd0);
        check("mid_rst_ram_req", 64'(vram.ram_req), 64'd0);
        check("mid_rst_ram_addr", 64'(vram.ram_addr), 64'd0);
        check("mid_rst_late", 64'(late), 64'd0);
        check("mid_rst_miss_cnt", 64'(miss_cnt), 64'd0);
        tick();
        check("stray_ack_ram_req", 64'(vram.ram_req), 64'd0);
        check("stray_ack_vdata", vram.vdata, 64'd0);
        repeat (3) tick();
        check("after_stray_ram_req", 64'(vram.ram_req), 64'd0);
        check("after_stray_ram_addr", 64'(vram.ram_addr), 64'd0);
        check("after_stray_vdata", vram.vdata, 64'd0);
        check("after_stray_miss_cnt", 64'(miss_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/viking_vram_responder.md
# viking_vram_responder

Memory-side responder for the Viking 1280x1024 monochrome video fetcher. It sits between the fetcher's 64-bit read port and the SDRAM controller's request/acknowledge port. Every video read is served by the fetcher's fixed latch point in bus cycle 1. Because the fetcher reads strictly sequential 4-word blocks, the responder hides RAM latency with a one-entry prefetch buffer and flags any missed deadline.

## Interface
- No parameters.
- pclk  in  1  128 MHz pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- clk_8_en  in  1  8 MHz bus enable, one pclk wide, mid-cycle.
- bus_cycle  in  2  current bus-cycle slot (0..3).
- vaddr  in  23  video word address from the fetcher.
- vread  in  1  video read request; valid only in bus_cycle 1.
- vdata  out  64  read data for the fetcher.
- ram_req  out  1  backend read request.
- ram_addr  out  23  backend word address, 4-word aligned.
- ram_ack  in  1  one-cycle pulse; ram_data is valid in the same cycle.
- ram_data  in  64  backend read data.
- late  out  1  sticky deadline-miss flag.
- miss_cnt  out  16  saturating count of prefetch misses.

## Operation
- Phase counter t[3:0]:
  - A rising edge of clk_8_en, detected against its one-cycle delay, loads t with 0xD; otherwise t increments.
  - phase = {bus_cycle, t} is registered, giving the same timebase as the fetcher.
- Sample point: phase 0x11. If vread=1, capture req_addr = vaddr; otherwise do nothing this bus cycle.
- Prefetch buffer: pf_valid, pf_addr[22:0], pf_data[63:0].
- States:
  - IDLE: no backend request.
  - DEMAND: fetching req_addr.
  - PREFETCH: fetching pf_addr.
  - DRAIN: an unwanted prefetch is in flight; wait for its ack, discard the data, then go to DEMAND.
- At the sample point, with vread=1:
  - Hit (pf_valid and pf_addr==vaddr): vdata <= pf_data next cycle; pf_addr <= vaddr+4; pf_valid <= 0; go to PREFETCH.
  - Prefetch in flight with pf_addr==vaddr: the state becomes DEMAND for the same address; the backend request is not restarted.
  - Prefetch in flight with a different address: go to DRAIN.
  - Otherwise (miss from IDLE): go to DEMAND for vaddr. miss_cnt increments, saturating at 0xFFFF.
- DEMAND ack: vdata <= ram_data; pf_addr <= req_addr+4; go to PREFETCH.
- PREFETCH ack: pf_data <= ram_data; pf_valid <= 1; go to IDLE.
- Address arithmetic: +4 is modulo 2^23 (0x7FFFFC+4 = 0x000000). Bits [1:0] of ram_addr are always 0.
- Deadline: at phase 0x1E, if the current request has not yet loaded vdata, set late <= 1. vdata keeps its old value and the late data is still written when it arrives. late clears only on reset.
- Backend handshake:
  - ram_req and ram_addr are held stable from assertion until ram_ack.
  - ram_req deasserts in the cycle after ack, or is replaced by the next request in that same cycle.
  - A ram_ack while ram_req=0 is ignored.

## Timing
- Reset values: vdata=0, ram_req=0, ram_addr=0, late=0, miss_cnt=0, pf_valid=0, state IDLE, t=0.
- Reset mid-transfer: ram_req drops on the next edge, and a later stray ack is ignored.
- Hit latency: vdata is valid at phase 0x12.
- Miss latency: vdata is valid one cycle after ram_ack. The deadline is met if ram_ack arrives at or before phase 0x1D.
- vdata must not change between phase 0x1D and 0x1F inclusive, except for a late load.
- Simultaneous events:
  - Ack in the sample cycle: the ack is processed first, and the sample then sees the updated pf_valid/pf_addr.
  - Ack in the deadline cycle: vdata loads, and late is still set.
- vread outside phase 0x11 has no effect.

## Structure
- Shared package viking_pkg holds:
  - the state enum;
  - phase constants SAMPLE=6'h11, DEADLINE=6'h1E, CLK8_LOAD=4'hD;
  - the 23-bit address width and BLOCK_WORDS=4.
- One sub-module, viking_phase_gen: produces t and the registered phase. The fetcher should share it.

## Test plan
- Cold miss, ack at phase 0x18, vaddr=0x600000:
  - ram_addr=0x600000;
  - vdata equals ram_data at 0x19;
  - then a prefetch at 0x600004;
  - late=0, miss_cnt=1.
- Sequential reads 0x600000, 0x600004, 0x600008 with fast acks: the 2nd and 3rd reads hit, vdata is valid at phase 0x12, miss_cnt stays 1.
- Slow backend, ack at phase 0x1F: late=1 and stays 1 after later good cycles; vdata updates at 0x20.
- Jump while a prefetch is in flight (prefetch 0x600004, request 0x740000): state goes to DRAIN, the old data is discarded, then ram_addr=0x740000; miss_cnt increments.
- Wrap: request 0x7FFFFC, then prefetch ram_addr=0x000000.
- Reset asserted while ram_req=1, then ram_ack pulsed: all outputs return to reset values, and the ack causes no state change.
